// File: rtl/pdp1_vga_pkg.sv
// Shared definitions for the PDP-1 VGA band filler: ring entry layout, row buffer geometry, FSM states.
package pdp1_vga_pkg;

    localparam int X_LSB         = 0;
    localparam int Y_LSB         = 10;
    localparam int I_LSB         = 20;
    localparam int ENTRY_W       = 28;
    localparam int ROWS_PER_BAND = 8;
    localparam int ROWBUF_AW     = 13;

    // Field order mirrors the {intensity, y, x} packing of the ring entry.
    typedef struct packed {
        logic [7:0] inten;
        logic [9:0] y;
        logic [9:0] x;
    } ring_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SCAN,
        ST_DRAIN,
        ST_FIN
    } state_t;

    function automatic ring_entry_t mk_entry(logic [7:0] i, logic [9:0] y, logic [9:0] x);
        ring_entry_t e;
        e.inten = i;
        e.y     = y;
        e.x     = x;
        return e;
    endfunction

endpackage

// File: rtl/pdp1_vga_band_filler_match.sv
// Registered match stage: turns a valid ring entry inside the current band into a row buffer write.
module pdp1_vga_band_match
    import pdp1_vga_pkg::*;
#(
    parameter int H_ACTIVE = 640
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 i_valid,
    input  ring_entry_t          i_entry,
    input  logic [6:0]           i_band_q,
    output logic                 o_wren,
    output logic [ROWBUF_AW-1:0] o_wraddress,
    output logic [7:0]           o_data
);

    logic                 w_hit;
    logic                 r_wren;
    logic [ROWBUF_AW-1:0] r_wraddress;
    logic [7:0]           r_data;

    // Zero intensity marks an empty ring slot.
    assign w_hit = i_valid && (i_entry.y[9:3] == i_band_q) &&
                   ({1'b0, i_entry.x} < 11'(H_ACTIVE)) && (i_entry.inten != 8'd0);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_wren      <= 1'b0;
            r_wraddress <= '0;
            r_data      <= '0;
        end else begin
            r_wren <= w_hit;
            if (w_hit) begin
                r_wraddress <= {i_entry.y[2:0], i_entry.x};
                r_data      <= i_entry.inten;
            end
        end
    end

    assign o_wren      = r_wren;
    assign o_wraddress = r_wraddress;
    assign o_data      = r_data;

endmodule

// File: rtl/pdp1_vga_band_filler.sv
// Row buffer writer: optionally clears a band, then scans the pixel ring and writes in-band pixels.
module pdp1_vga_band_filler
    import pdp1_vga_pkg::*;
#(
    parameter int RING_AW  = 10,
    parameter int H_ACTIVE = 640,
    parameter bit CLEAR_EN = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 band_start,
    input  logic [9:0]           band_y,
    output logic [RING_AW-1:0]   rb_addr,
    input  logic [ENTRY_W-1:0]   rb_data,
    output logic [ROWBUF_AW-1:0] rowbuf_wraddress,
    output logic [7:0]           rowbuf_data,
    output logic                 rowbuf_wren,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun
);

    localparam logic [9:0]         COL_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0]         COL_ONE  = 10'd1;
    localparam logic [2:0]         ROW_ONE  = 3'd1;
    localparam logic [RING_AW-1:0] SCAN_ONE = RING_AW'(1);

    state_t                 r_state;
    logic [6:0]             r_band_q;
    logic [2:0]             r_row;
    logic [9:0]             r_col;
    logic [RING_AW-1:0]     r_scan;
    logic [RING_AW-1:0]     r_rb_addr;
    logic [1:0]             r_vld_pipe;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_overrun;
    logic                   r_clr_wren;
    logic [ROWBUF_AW-1:0]   r_clr_addr;

    logic                   w_m_wren;
    logic [ROWBUF_AW-1:0]   w_m_addr;
    logic [7:0]             w_m_data;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_band_q   <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_scan     <= '0;
            r_rb_addr  <= '0;
            r_vld_pipe <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overrun  <= 1'b0;
            r_clr_wren <= 1'b0;
            r_clr_addr <= '0;
        end else begin
            r_done     <= 1'b0;
            r_clr_wren <= 1'b0;
            r_overrun  <= band_start && (r_state != ST_IDLE);
            // [0] tracks rb_addr, [1] tracks the returned rb_data.
            r_vld_pipe <= {r_vld_pipe[0], r_state == ST_SCAN};
            case (r_state)
                ST_IDLE: begin
                    if (band_start) begin
                        r_band_q <= band_y[9:3];
                        r_busy   <= 1'b1;
                        r_row    <= '0;
                        r_col    <= '0;
                        r_scan   <= '0;
                        r_state  <= CLEAR_EN ? ST_CLEAR : ST_SCAN;
                    end
                end
                ST_CLEAR: begin
                    r_clr_wren <= 1'b1;
                    r_clr_addr <= {r_row, r_col};
                    if (r_col == COL_LAST) begin
                        r_col <= '0;
                        r_row <= r_row + ROW_ONE;
                        if (r_row == 3'd7) r_state <= ST_SCAN;
                    end else begin
                        r_col <= r_col + COL_ONE;
                    end
                end
                ST_SCAN: begin
                    r_rb_addr <= r_scan;
                    if (&r_scan) r_state <= ST_DRAIN;
                    else         r_scan  <= r_scan + SCAN_ONE;
                end
                ST_DRAIN: r_state <= ST_FIN;
                ST_FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    pdp1_vga_band_match #(
        .H_ACTIVE (H_ACTIVE)
    ) u_match (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_valid     (r_vld_pipe[1]),
        .i_entry     (ring_entry_t'(rb_data)),
        .i_band_q    (r_band_q),
        .o_wren      (w_m_wren),
        .o_wraddress (w_m_addr),
        .o_data      (w_m_data)
    );

    // Clear and match writes never overlap in time, so a register-select is enough.
    assign rowbuf_wren      = r_clr_wren | w_m_wren;
    assign rowbuf_wraddress = r_clr_wren ? r_clr_addr : w_m_addr;
    assign rowbuf_data      = r_clr_wren ? 8'd0 : w_m_data;
    assign rb_addr          = r_rb_addr;
    assign busy             = r_busy;
    assign done             = r_done;
    assign overrun          = r_overrun;

endmodule

// File: tb/tb_pdp1_vga_band_filler.sv
// Directed bench: CLEAR_EN=1 and CLEAR_EN=0 instances fed from one modelled pixel ring.
module tb_pdp1_vga_band_filler;
    import pdp1_vga_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        bs0 = 1'b0, bs1 = 1'b0;
    logic [9:0]  band_y = '0;
    logic [9:0]  rb_addr0, rb_addr1;
    logic [27:0] rb_data0 = '0, rb_data1 = '0;
    logic [12:0] addr0, addr1;
    logic [7:0]  data0, data1;
    logic        wren0, wren1, busy0, busy1, done0, done1, ovr0, ovr1;

    logic [27:0] ring [1024];

    int n_chk = 0, n_fail = 0;
    int zc[2], nzc[2], dc[2], badz, zdist;
    logic [12:0] la[2];
    logic [7:0]  ld[2];
    bit cov[8192];

    always #5 clk = ~clk;

    pdp1_vga_band_filler #(.RING_AW(10), .H_ACTIVE(640), .CLEAR_EN(1'b1)) dut0 (
        .clock(clk), .reset_n(reset_n), .band_start(bs0), .band_y(band_y),
        .rb_addr(rb_addr0), .rb_data(rb_data0), .rowbuf_wraddress(addr0),
        .rowbuf_data(data0), .rowbuf_wren(wren0), .busy(busy0), .done(done0), .overrun(ovr0));

    pdp1_vga_band_filler #(.RING_AW(10), .H_ACTIVE(640), .CLEAR_EN(1'b0)) dut1 (
        .clock(clk), .reset_n(reset_n), .band_start(bs1), .band_y(band_y),
        .rb_addr(rb_addr1), .rb_data(rb_data1), .rowbuf_wraddress(addr1),
        .rowbuf_data(data1), .rowbuf_wren(wren1), .busy(busy1), .done(done1), .overrun(ovr1));

    // Ring read port: one-cycle registered read.
    always @(posedge clk) begin
        rb_data0 <= ring[rb_addr0];
        rb_data1 <= ring[rb_addr1];
    end

    always @(negedge clk) begin
        if (wren0 === 1'b1) begin
            if (data0 == 8'd0) begin
                zc[0]++;
                if (addr0[9:0] >= 10'd640) badz++;
                else if (!cov[addr0]) begin cov[addr0] = 1'b1; zdist++; end
            end else begin
                nzc[0]++; la[0] = addr0; ld[0] = data0;
            end
        end
        if (wren1 === 1'b1) begin
            if (data1 == 8'd0) zc[1]++;
            else begin nzc[1]++; la[1] = addr1; ld[1] = data1; end
        end
        if (done0 === 1'b1) dc[0]++;
        if (done1 === 1'b1) dc[1]++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        for (int s = 0; s < 2; s++) begin zc[s] = 0; nzc[s] = 0; dc[s] = 0; la[s] = '0; ld[s] = '0; end
        badz = 0; zdist = 0;
        foreach (cov[i]) cov[i] = 1'b0;
    endtask

    task automatic clear_ring();
        foreach (ring[i]) ring[i] = '0;
    endtask

    task automatic set_bs(input int sel, input logic v);
        if (sel == 0) bs0 = v; else bs1 = v;
    endtask

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy0 : busy1;
    endfunction

    function automatic logic get_done(input int sel);
        return (sel == 0) ? done0 : done1;
    endfunction

    function automatic logic get_ovr(input int sel);
        return (sel == 0) ? ovr0 : ovr1;
    endfunction

    // Launch a band and measure cycles from busy rising to done; optional overrun poke at ovr_at.
    task automatic run_band(input int sel, input logic [9:0] y, input int ovr_at, input int exp_lat);
        int cnt;
        bit got;
        clear_stats();
        @(negedge clk);
        band_y = y; set_bs(sel, 1'b1);
        @(negedge clk);
        set_bs(sel, 1'b0);
        chk("busy_rise", get_busy(sel), 1);
        cnt = 0; got = 0;
        while (cnt < 20000 && !got) begin
            @(negedge clk);
            cnt++;
            if (ovr_at > 0 && cnt == ovr_at) begin band_y = 10'd8; set_bs(sel, 1'b1); end
            if (ovr_at > 0 && cnt == ovr_at + 1) begin
                set_bs(sel, 1'b0); band_y = y;
                chk("overrun_pulse", get_ovr(sel), 1);
            end
            if (get_done(sel) === 1'b1) got = 1;
        end
        chk("done_seen", got, 1);
        chk("done_latency", cnt, exp_lat);
        chk("busy_at_done", get_busy(sel), 0);
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        int          i0;
        logic [27:0] e0;
        int          i1;
        logic [27:0] e1;
        logic [9:0]  y;
        int          exp_nz;
        logic [12:0] exp_addr;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t vt[6];

    initial begin
        int zsnap;
        vt[0] = '{-1, '0, -1, '0, 10'd16, 0, '0, '0};
        vt[1] = '{5, mk_entry(8'hC0, 10'd19, 10'd100), 6, mk_entry(8'h40, 10'd24, 10'd3),
                  10'd16, 1, {3'd3, 10'd100}, 8'hC0};
        vt[2] = '{3, mk_entry(8'hFF, 10'd17, 10'd640), 4, mk_entry(8'h00, 10'd17, 10'd10),
                  10'd16, 0, '0, '0};
        vt[3] = '{2, mk_entry(8'hAA, 10'd20, 10'd50), 9, mk_entry(8'h55, 10'd20, 10'd50),
                  10'd23, 2, {3'd4, 10'd50}, 8'h55};
        vt[4] = '{7, mk_entry(8'h11, 10'd1023, 10'd639), -1, '0,
                  10'd1016, 1, {3'd7, 10'd639}, 8'h11};
        vt[5] = '{1023, mk_entry(8'h22, 10'd16, 10'd0), -1, '0,
                  10'd16, 1, {3'd0, 10'd0}, 8'h22};

        clear_ring();
        clear_stats();

        // Reset and idle behaviour.
        repeat (5) @(negedge clk);
        chk("reset_outs0", {rb_addr0, addr0, data0, wren0, busy0, done0, ovr0}, 0);
        chk("reset_outs1", {rb_addr1, addr1, data1, wren1, busy1, done1, ovr1}, 0);
        reset_n = 1'b1;
        clear_stats();
        repeat (10) @(negedge clk);
        chk("idle_rb_addr", rb_addr0, 0);
        chk("idle_no_wren", zc[0] + nzc[0] + zc[1] + nzc[1], 0);

        // Reset in the middle of CLEAR abandons the fill.
        band_y = 10'd16; bs0 = 1'b1;
        @(negedge clk);
        bs0 = 1'b0;
        repeat (100) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midclr_wren", wren0, 0);
        chk("midclr_busy", busy0, 0);
        zsnap = zc[0];
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("midclr_no_writes", zc[0], zsnap);
        chk("midclr_idle_busy", busy0, 0);

        // Table of full fills on the clearing instance.
        for (int v = 0; v < 6; v++) begin
            clear_ring();
            if (vt[v].i0 >= 0) ring[vt[v].i0] = vt[v].e0;
            if (vt[v].i1 >= 0) ring[vt[v].i1] = vt[v].e1;
            run_band(0, vt[v].y, 0, 6146);
            chk("clear_writes", zc[0], 5120);
            chk("clear_coverage", zdist, 5120);
            chk("clear_in_range", badz, 0);
            chk("nz_writes", nzc[0], vt[v].exp_nz);
            if (vt[v].exp_nz > 0) begin
                chk("nz_addr", la[0], vt[v].exp_addr);
                chk("nz_data", ld[0], vt[v].exp_data);
            end
            chk("done_count", dc[0], 1);
        end

        // Overrun during SCAN and during FIN: band_q kept, single done, no restart.
        clear_ring();
        ring[5] = mk_entry(8'hC0, 10'd19, 10'd100);
        run_band(0, 10'd16, 5200, 6146);
        chk("ovr_scan_nz", nzc[0], 1);
        chk("ovr_scan_addr", la[0], {3'd3, 10'd100});
        chk("ovr_scan_done", dc[0], 1);
        run_band(0, 10'd16, 6145, 6146);
        chk("ovr_fin_nz", nzc[0], 1);
        chk("ovr_fin_done", dc[0], 1);
        chk("ovr_fin_no_restart", busy0, 0);

        // No-clear instance: scan starts right away, 1026-cycle fill.
        begin
            int cnt;
            bit got;
            clear_stats();
            @(negedge clk);
            band_y = 10'd16; bs1 = 1'b1;
            @(negedge clk);
            bs1 = 1'b0;
            chk("nc_busy_rise", busy1, 1);
            cnt = 0; got = 0;
            while (cnt < 5000 && !got) begin
                @(negedge clk);
                cnt++;
                if (cnt == 2) chk("nc_rb_addr1", rb_addr1, 1);
                if (cnt == 6) chk("nc_rb_addr5", rb_addr1, 5);
                if (cnt == 7) chk("nc_wren_before", wren1, 0);
                if (cnt == 8) chk("nc_match_write", {wren1, addr1, data1}, {1'b1, 3'd3, 10'd100, 8'hC0});
                if (done1 === 1'b1) got = 1;
            end
            chk("nc_done_seen", got, 1);
            chk("nc_done_latency", cnt, 1026);
            repeat (3) @(negedge clk);
            chk("nc_zero_writes", zc[1], 0);
            chk("nc_nz_writes", nzc[1], 1);
            chk("nc_done_count", dc[1], 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
